// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage.
// Instruction field layout and the NOP word.
package if_stage_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

endpackage

// File: rtl/if_stage_hazard_unit.sv
// Load-use and branch-after-load hazard detection.
// Purely combinational; register 0 never stalls.
module hazard_unit #(
  parameter int REG_DIR_WIDTH = 3
) (
  input  logic [REG_DIR_WIDTH-1:0] rs,
  input  logic [REG_DIR_WIDTH-1:0] rt,
  input  logic                     id_branch,
  input  logic                     idex_mem_read,
  input  logic [REG_DIR_WIDTH-1:0] idex_rt,
  input  logic                     exmem_mem_read,
  input  logic [REG_DIR_WIDTH-1:0] exmem_rt,
  output logic                     stall
);

  logic stall_lu;
  logic stall_br;

  assign stall_lu = idex_mem_read
                 && (idex_rt != '0)
                 && ((idex_rt == rs) || (idex_rt == rt));

  // Branch compare forwards only from EX, so a
  // load still in MEM must hold the branch.
  assign stall_br = id_branch
                 && exmem_mem_read
                 && (exmem_rt != '0)
                 && ((exmem_rt == rs) || (exmem_rt == rt));

  assign stall = stall_lu || stall_br;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, IF/ID register,
// hazard stall and branch redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          PC_WIDTH      = 6,
  parameter int          REG_DIR_WIDTH = 3,
  parameter logic [31:0] NOP_WORD      = if_stage_pkg::NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     IF_Flush,
  input  logic [PC_WIDTH-1:0]      ALUR,
  input  logic                     ID_Branch,
  input  logic                     IDEX_MemRead,
  input  logic [REG_DIR_WIDTH-1:0] IDEX_RegisterRt,
  input  logic                     EXMEM_MemRead,
  input  logic [REG_DIR_WIDTH-1:0] EXMEM_RegisterRt,
  input  logic [31:0]              imem_data,
  output logic [PC_WIDTH-1:0]      imem_addr,
  output logic [31:0]              Instruction,
  output logic [PC_WIDTH-1:0]      PCNext,
  output logic [REG_DIR_WIDTH-1:0] IFID_RegisterRs,
  output logic [REG_DIR_WIDTH-1:0] IFID_RegisterRt,
  output logic                     Stall,
  output logic                     Bubble
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc + PC_WIDTH'(1);
  assign imem_addr = pc;

  assign IFID_RegisterRs =
    Instruction[RS_LSB +: REG_DIR_WIDTH];
  assign IFID_RegisterRt =
    Instruction[RT_LSB +: REG_DIR_WIDTH];

  hazard_unit #(
    .REG_DIR_WIDTH(REG_DIR_WIDTH)
  ) u_hazard (
    .rs             (IFID_RegisterRs),
    .rt             (IFID_RegisterRt),
    .id_branch      (ID_Branch),
    .idex_mem_read  (IDEX_MemRead),
    .idex_rt        (IDEX_RegisterRt),
    .exmem_mem_read (EXMEM_MemRead),
    .exmem_rt       (EXMEM_RegisterRt),
    .stall          (Stall)
  );

  assign Bubble = Stall;

  // A stalled branch used stale operands, so
  // the stall must win over the flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      Instruction <= NOP_WORD;
      PCNext      <= '0;
    end else if (Stall) begin
      pc          <= pc;
      Instruction <= Instruction;
      PCNext      <= PCNext;
    end else if (IF_Flush) begin
      pc          <= ALUR;
      Instruction <= NOP_WORD;
      PCNext      <= '0;
    end else begin
      pc          <= pc_inc;
      Instruction <= imem_data;
      PCNext      <= pc_inc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes
// expected observations, a monitor pops them.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IF_Flush = 1'b0;
  logic [5:0]  ALUR = '0;
  logic        ID_Branch = 1'b0;
  logic        IDEX_MemRead = 1'b0;
  logic [2:0]  IDEX_RegisterRt = '0;
  logic        EXMEM_MemRead = 1'b0;
  logic [2:0]  EXMEM_RegisterRt = '0;
  logic [31:0] imem_data;
  logic [5:0]  imem_addr;
  logic [31:0] Instruction;
  logic [5:0]  PCNext;
  logic [2:0]  IFID_RegisterRs;
  logic [2:0]  IFID_RegisterRt;
  logic        Stall;
  logic        Bubble;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] instr;
    logic [5:0]  pcn;
    logic        stall;
    logic        bubble;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Word 8 carries Rs=3, word 9 carries Rt=4.
  function automatic logic [31:0] w(input logic [5:0] a);
    case (a)
      6'd8:    w = 32'h1060_0008;
      6'd9:    w = 32'h1004_0009;
      default: w = 32'h1000_0000 | {26'd0, a};
    endcase
  endfunction

  assign imem_data = w(imem_addr);

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .IF_Flush         (IF_Flush),
    .ALUR             (ALUR),
    .ID_Branch        (ID_Branch),
    .IDEX_MemRead     (IDEX_MemRead),
    .IDEX_RegisterRt  (IDEX_RegisterRt),
    .EXMEM_MemRead    (EXMEM_MemRead),
    .EXMEM_RegisterRt (EXMEM_RegisterRt),
    .imem_data        (imem_data),
    .imem_addr        (imem_addr),
    .Instruction      (Instruction),
    .PCNext           (PCNext),
    .IFID_RegisterRs  (IFID_RegisterRs),
    .IFID_RegisterRt  (IFID_RegisterRt),
    .Stall            (Stall),
    .Bubble           (Bubble)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string nm, input logic [5:0] a,
                      input logic [31:0] i, input logic [5:0] p,
                      input logic s);
    obs_t o;
    o.addr = a;
    o.instr = i;
    o.pcn = p;
    o.stall = s;
    o.bubble = s;
    exp_q.push_back(o);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm,
                      input logic fl, input logic [5:0] tgt,
                      input logic br,
                      input logic imr, input logic [2:0] irt,
                      input logic emr, input logic [2:0] ert,
                      input logic [5:0] ea, input logic [31:0] ei,
                      input logic [5:0] ep, input logic es);
    @(posedge clk);
    #1;
    IF_Flush = fl;
    ALUR = tgt;
    ID_Branch = br;
    IDEX_MemRead = imr;
    IDEX_RegisterRt = irt;
    EXMEM_MemRead = emr;
    EXMEM_RegisterRt = ert;
    push(nm, ea, ei, ep, es);
  endtask

  // Monitor: sample every negedge and on async reset.
  initial begin
    obs_t  got;
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        got.addr = imem_addr;
        got.instr = Instruction;
        got.pcn = PCNext;
        got.stall = Stall;
        got.bubble = Bubble;
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL %s: got addr=%h instr=%h pcn=%h stall=%b bubble=%b, want addr=%h instr=%h pcn=%h stall=%b bubble=%b",
                   nm, got.addr, got.instr, got.pcn, got.stall,
                   got.bubble, e.addr, e.instr, e.pcn, e.stall,
                   e.bubble);
        end
      end
    end
  end

  initial begin
    logic [5:0] c6;
    logic [5:0] p6;
    int n;
    // In reset, a load to r3 must not stall on NOPs.
    step("reset", 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    IDEX_MemRead = 0;
    IDEX_RegisterRt = 0;
    rst = 1;
    for (int c = 1; c <= 66; c++) begin
      c6 = 6'(c);
      p6 = 6'(c - 1);
      step("run", 0, 0, 0, 0, 0, 0, 0, c6, w(p6), c6, 0);
    end
    step("pre_flush", 1, 6'h2A, 0, 0, 0, 0, 0,
         6'd3, w(6'd2), 6'd3, 0);
    step("flush_2a", 0, 0, 0, 0, 0, 0, 0, 6'h2A, 0, 0, 0);
    step("fetch_2a", 1, 6'd8, 0, 0, 0, 0, 0,
         6'h2B, 32'h1000_002A, 6'h2B, 0);
    step("flush_8", 0, 0, 0, 0, 0, 0, 0, 6'd8, 0, 0, 0);
    step("lu_stall", 0, 0, 0, 1, 3, 0, 0,
         6'd9, 32'h1060_0008, 6'd9, 1);
    step("lu_stall2", 0, 0, 0, 1, 3, 0, 0,
         6'd9, 32'h1060_0008, 6'd9, 1);
    step("lu_hold", 0, 0, 0, 0, 0, 0, 0,
         6'd9, 32'h1060_0008, 6'd9, 0);
    step("r0_nostall", 0, 0, 1, 1, 0, 1, 0,
         6'd10, 32'h1004_0009, 6'd10, 0);
    step("pre_flush9", 1, 6'd9, 0, 0, 0, 0, 0,
         6'd11, 32'h1000_000A, 6'd11, 0);
    step("flush_9", 0, 0, 0, 0, 0, 0, 0, 6'd9, 0, 0, 0);
    step("br_stall", 1, 6'h30, 1, 0, 0, 1, 4,
         6'd10, 32'h1004_0009, 6'd10, 1);
    step("br_hold", 1, 6'h30, 0, 0, 0, 0, 0,
         6'd10, 32'h1004_0009, 6'd10, 0);
    step("flush_30", 0, 0, 0, 0, 0, 0, 0, 6'h30, 0, 0, 0);
    step("fetch_30", 0, 0, 0, 0, 0, 0, 0,
         6'h31, 32'h1000_0030, 6'h31, 0);
    step("pre_flush8b", 1, 6'd8, 0, 0, 0, 0, 0,
         6'h32, 32'h1000_0031, 6'h32, 0);
    step("flush_8b", 0, 0, 0, 0, 0, 0, 0, 6'd8, 0, 0, 0);
    step("lu_stall3", 0, 0, 0, 1, 3, 0, 0,
         6'd9, 32'h1060_0008, 6'd9, 1);
    @(negedge clk);
    #3;
    push("async_rst", 0, 0, 0, 0);
    rst = 0;
    #1;
    step("rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    rst = 1;
    step("restart0", 0, 0, 0, 0, 0, 0, 0,
         6'd1, 32'h1000_0000, 6'd1, 0);
    step("restart1", 0, 0, 0, 0, 0, 0, 0,
         6'd2, 32'h1000_0001, 6'd2, 0);
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
